sk9822_frame_src: RTL and testbench

Upstream frame source for the SK9822 serial LED driver. It holds a per-LED colour/brightness buffer that a host writes, and emits a complete SK9822 frame as a stream of 32-bit words over a valid/ready handshake: one start word, `LED_NUM` LED words, then the end word(s). The serializer consumes these words and shifts them out on CK/DA. A frame goes out on a periodic refresh tick or on host request. Host writes are double-buffered, so a frame is never sent half-updated.

---
 rtl/sk9822_frame_src_if.sv | 22 ++
 rtl/sk9822_frame_src.sv | 194 +++++++++++++++++++
 tb/tb_sk9822_frame_src.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sk9822_frame_src_if.sv
// Word stream from the frame source to the SK9822 serializer.
// Words move on a rising edge where out_valid and out_ready are both high.
interface sk9822_frame_src_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;

    modport master (
        output out_valid,
        output out_word,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_word,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sk9822_frame_src.sv
// SK9822 frame source: double-buffered LED colours streamed as start, LED and end words.
// First word one cycle after a request (plus LED_NUM copy cycles on commit); holds word while out_ready low.
module sk9822_frame_src #(
    parameter int unsigned LED_NUM    = 11,
    parameter int unsigned CLK_FRE    = 27_000_000,
    parameter int unsigned REFRESH_HZ = 60,
    parameter logic [4:0]  DEF_BRIGHT = 5'b01111
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [7:0]         wr_addr,
    input  logic [28:0]        wr_data,
    input  logic               commit,
    input  logic               start,
    sk9822_frame_src_if.master out_if,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned END_WORDS  = (LED_NUM + 63) / 64;
    localparam int unsigned AW         = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(LED_NUM - 1);
    localparam logic [2:0]  LAST_END   = 3'(END_WORDS - 1);
    localparam logic [8:0]  LED_LIMIT  = 9'(LED_NUM);
    localparam logic [28:0] DEF_ENTRY  = {DEF_BRIGHT, 24'h00_0000};

    localparam int unsigned PERIOD_RAW = (REFRESH_HZ == 0) ? 1 : CLK_FRE / REFRESH_HZ;
    localparam int unsigned PERIOD     = (PERIOD_RAW == 0) ? 1 : PERIOD_RAW;
    localparam logic [31:0] TMR_LAST   = 32'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COPY,
        S_START,
        S_LED,
        S_END
    } state_t;

    logic [28:0] staging_q [LED_NUM];
    logic [28:0] active_q  [LED_NUM];

    state_t        state_q;
    logic          req_pend_q;
    logic          commit_pend_q;
    logic [AW-1:0] idx_q;
    logic [2:0]    end_cnt_q;
    logic          out_valid_q;
    logic [31:0]   out_word_q;
    logic          out_last_q;
    logic          busy_q;
    logic          done_q;
    logic [31:0]   timer_q;

    logic addr_ok;
    logic tick;
    logic xfer;
    logic copy_bypass;

    function automatic logic [31:0] led_word(input logic [28:0] entry);
        return {3'b111, entry};
    endfunction

    assign addr_ok     = ({1'b0, wr_addr} < LED_LIMIT);
    assign tick        = (REFRESH_HZ != 0) && (timer_q == TMR_LAST);
    assign xfer        = out_valid_q && out_if.out_ready;
    // A write landing on the entry being copied this cycle must reach active too.
    assign copy_bypass = wr_en && addr_ok && (wr_addr[AW-1:0] == idx_q);

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_word  = out_word_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = busy_q;
    assign frame_done       = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (REFRESH_HZ == 0) begin
            timer_q <= '0;
        end else if (tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_q <= '{default: DEF_ENTRY};
        end else if (wr_en && addr_ok) begin
            staging_q[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_pend_q    <= 1'b0;
            commit_pend_q <= 1'b0;
            idx_q         <= '0;
            end_cnt_q     <= '0;
            out_valid_q   <= 1'b0;
            out_word_q    <= '0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            active_q      <= '{default: DEF_ENTRY};
        end else begin
            done_q <= 1'b0;

            // New requests win over the clear so one arriving as IDLE exits is not lost.
            if (start || tick) begin
                req_pend_q <= 1'b1;
            end else if (state_q == S_IDLE) begin
                req_pend_q <= 1'b0;
            end

            if (commit) begin
                commit_pend_q <= 1'b1;
            end else if (state_q == S_IDLE && req_pend_q) begin
                commit_pend_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (req_pend_q) begin
                        busy_q <= 1'b1;
                        idx_q  <= '0;
                        if (commit_pend_q) begin
                            state_q <= S_COPY;
                        end else begin
                            state_q     <= S_START;
                            out_valid_q <= 1'b1;
                            out_word_q  <= '0;
                        end
                    end
                end

                S_COPY: begin
                    active_q[idx_q] <= copy_bypass ? wr_data : staging_q[idx_q];
                    if (idx_q == LAST_IDX) begin
                        state_q     <= S_START;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_word_q  <= '0;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end

                S_START: begin
                    if (xfer) begin
                        state_q    <= S_LED;
                        out_word_q <= led_word(active_q[0]);
                    end
                end

                S_LED: begin
                    if (xfer) begin
                        if (idx_q == LAST_IDX) begin
                            state_q    <= S_END;
                            end_cnt_q  <= '0;
                            out_word_q <= 32'hFFFF_FFFF;
                            out_last_q <= (END_WORDS == 1);
                        end else begin
                            idx_q      <= idx_q + AW'(1);
                            out_word_q <= led_word(active_q[idx_q + AW'(1)]);
                        end
                    end
                end

                S_END: begin
                    if (xfer) begin
                        if (end_cnt_q == LAST_END) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            out_word_q  <= '0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            end_cnt_q  <= end_cnt_q + 3'd1;
                            out_last_q <= ((end_cnt_q + 3'd1) == LAST_END);
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sk9822_frame_src.sv
// Scoreboard bench: a frame-level model pushes expected words, negedge monitors pop and compare.
module tb_sk9822_frame_src;

    localparam int N   = 11;
    localparam int N2  = 70;
    localparam int EW  = (N + 63) / 64;
    localparam int EW2 = (N2 + 63) / 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst2_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [28:0] wr_data;
    logic        commit, start;
    logic        busy, frame_done;
    logic        busy2, frame_done2;

    sk9822_frame_src_if bus();
    sk9822_frame_src_if bus2();

    sk9822_frame_src #(.LED_NUM(N), .REFRESH_HZ(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .start(start), .out_if(bus), .busy(busy), .frame_done(frame_done)
    );

    // Timer-driven instance: 100-cycle refresh period and two end words.
    sk9822_frame_src #(.LED_NUM(N2), .CLK_FRE(100), .REFRESH_HZ(1)) dut2 (
        .clk(clk), .rst_n(rst2_n), .wr_en(1'b0), .wr_addr(8'd0), .wr_data(29'd0),
        .commit(1'b0), .start(1'b0), .out_if(bus2), .busy(busy2), .frame_done(frame_done2)
    );

    assign bus2.out_ready = 1'b1;

    typedef struct packed {
        logic [31:0] w;
        logic        l;
    } exp_t;

    exp_t        expq[$];
    int          errors = 0;
    int          checks = 0;
    int          xfers  = 0;
    bit          rdy_rand = 1'b0;
    logic [28:0] m_stage [N];
    logic [28:0] m_active[N];
    bit          m_commit;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    task automatic tick_();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_stage[i]  = {5'b01111, 24'h0};
            m_active[i] = {5'b01111, 24'h0};
        end
        m_commit = 1'b0;
    endtask

    task automatic push_frame();
        exp_t e;
        if (m_commit) begin
            for (int i = 0; i < N; i++) m_active[i] = m_stage[i];
            m_commit = 1'b0;
        end
        e.w = 32'h0; e.l = 1'b0;
        expq.push_back(e);
        for (int i = 0; i < N; i++) begin
            e.w = {3'b111, m_active[i]};
            e.l = 1'b0;
            expq.push_back(e);
        end
        for (int i = 0; i < EW; i++) begin
            e.w = 32'hFFFF_FFFF;
            e.l = (i == EW - 1);
            expq.push_back(e);
        end
    endtask

    task automatic host_write(input int addr, input logic [28:0] data);
        wr_en = 1'b1; wr_addr = 8'(addr); wr_data = data;
        tick_();
        wr_en = 1'b0;
        if (addr < N) m_stage[addr] = data;
    endtask

    task automatic host_commit();
        commit = 1'b1;
        tick_();
        commit = 1'b0;
        m_commit = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick_();
        start = 1'b0;
    endtask

    task automatic start_measure(input int exp_lat, input string nm);
        int cnt = 0;
        start = 1'b1;
        tick_();
        start = 1'b0;
        while (!bus.out_valid && cnt < 300) begin
            tick_();
            cnt++;
        end
        chk(nm, cnt, exp_lat);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (expq.size() != 0 && n < 5000) begin
            tick_();
            n++;
        end
        if (expq.size() != 0) begin
            timeout(nm);
            expq.delete();
        end
        repeat (3) tick_();
        chk({nm, "_busy"}, busy, 1'b0);
    endtask

    task automatic wait_xfers(input int target, input string nm);
        int n = 0;
        while (xfers < target && n < 500) begin
            tick_();
            n++;
        end
        if (xfers < target) timeout(nm);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Main monitor: scoreboard pop, stall stability and frame_done timing.
    bit          stall_p  = 1'b0;
    bit          done_exp = 1'b0;
    logic [31:0] stall_w;
    logic        stall_l;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p  = 1'b0;
            done_exp = 1'b0;
        end else begin
            if (frame_done || done_exp) chk("frame_done", frame_done, done_exp);
            if (done_exp) chk("busy_after_done", busy, 1'b0);
            done_exp = 1'b0;
            if (stall_p) begin
                chk("stall_valid", bus.out_valid, 1'b1);
                chk("stall_word", bus.out_word, stall_w);
                chk("stall_last", bus.out_last, stall_l);
            end
            stall_p = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h expected none", bus.out_word);
                    end else begin
                        exp_t e;
                        e = expq.pop_front();
                        chk("word", bus.out_word, e.w);
                        chk("last", bus.out_last, e.l);
                    end
                    xfers++;
                    if (bus.out_last) done_exp = 1'b1;
                end else begin
                    stall_p = 1'b1;
                    stall_w = bus.out_word;
                    stall_l = bus.out_last;
                end
            end
        end
    end

    // Refresh monitor: position-based word check and start-to-start spacing.
    int pos2 = 0, frames2 = 0, cyc2 = 0, last_start2 = 0;

    always @(negedge clk) begin
        cyc2++;
        if (!rst2_n) begin
            pos2 = 0;
        end else if (bus2.out_valid) begin
            logic [31:0] ew;
            ew = (pos2 == 0) ? 32'h0 : (pos2 <= N2) ? 32'hEF00_0000 : 32'hFFFF_FFFF;
            chk("refresh_word", bus2.out_word, ew);
            chk("refresh_last", bus2.out_last, (pos2 == N2 + EW2));
            if (pos2 == 0) begin
                if (frames2 > 0) chk("refresh_period", cyc2 - last_start2, 100);
                last_start2 = cyc2;
                frames2++;
            end
            pos2 = (pos2 == N2 + EW2) ? 0 : pos2 + 1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        rst_n = 1'b0; rst2_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; start = 1'b0;
        m_reset();
        repeat (3) tick_();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_word", bus.out_word, 32'h0);
        chk("rst_last", bus.out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        rst_n = 1'b1; rst2_n = 1'b1;
        repeat (2) tick_();

        // Default frame with ready held high.
        rdy_rand = 1'b0;
        push_frame();
        start_measure(1, "latency_plain");
        wait_idle("default_frame");

        // Committed single-LED update goes through COPY first.
        host_write(3, 29'h1F_0000FF);
        host_commit();
        push_frame();
        start_measure(1 + N, "latency_commit");
        wait_idle("commit_frame");

        // Random writes and commits under random backpressure.
        rdy_rand = 1'b1;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 3; k++) host_write($urandom_range(0, N + 3), 29'($urandom));
            if ($urandom_range(0, 1) == 1) host_commit();
            push_frame();
            pulse_start();
            wait_idle("random_frame");
        end

        // Mid-frame commit and repeated starts collapse into one follow-up frame.
        push_frame();
        x0 = xfers;
        pulse_start();
        wait_xfers(x0 + 3, "midframe_wait");
        host_write(0, 29'h0A_123456);
        host_write(N - 1, 29'h15_ABCDEF);
        host_commit();
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            tick_();
        end
        push_frame();
        wait_idle("midframe");
        repeat (60) tick_();
        chk("no_extra_frame", busy, 1'b0);

        // Out-of-range writes leave every LED untouched.
        host_write(N, 29'h1F_FFFFFF);
        host_write(200, 29'h1F_FFFFFF);
        host_commit();
        push_frame();
        pulse_start();
        wait_idle("oob_write");

        // Reset during LED_F truncates the frame and restores both buffers.
        host_write(5, 29'h13_00FF00);
        host_commit();
        push_frame();
        x0 = xfers;
        pulse_start();
        host_write(6, 29'h11_0F0F0F);
        wait_xfers(x0 + 4, "reset_wait");
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_word", bus.out_word, 32'h0);
        chk("midrst_last", bus.out_last, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        expq.delete();
        m_reset();
        tick_();
        rst_n = 1'b1;
        tick_();
        host_commit();
        push_frame();
        start_measure(1 + N, "latency_after_reset");
        wait_idle("after_reset");

        chk("refresh_frames", (frames2 >= 3), 1'b1);
        chk("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
